uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 1250, meaning clock cycles per baud; legal values are 8 or more.
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame; legal range is 5..9.
REQ-003 SHALL have parameter PARITY, default 0, meaning 0=none, 1=odd, 2=even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; legal values are 1 or 2.
REQ-005 SHALL have port CLK, input, 1 bit: system clock; all logic on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port RX, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port DATA, output, DATA_BITS bits: received payload, LSB first on the line.
REQ-009 SHALL have port VALID, output, 1 bit: DATA and the error flags hold a frame.
REQ-010 SHALL have port READY, input, 1 bit: consumer accepts the frame when VALID and READY are both 1.
REQ-011 SHALL have port PARITY_ERR, output, 1 bit: the parity check failed for the held frame.
REQ-012 SHALL have port FRAME_ERR, output, 1 bit: a stop bit was sampled 0 for the held frame.
REQ-013 SHALL have port OVERRUN, output, 1 bit: one-cycle pulse when a completed frame is dropped.
REQ-014 SHALL have port BUSY, output, 1 bit: high in every state except IDLE.

Function
REQ-015 SHALL pass RX through a two-flop synchronizer; all decisions use the synchronized value RXS.
REQ-016 SHALL implement the states IDLE, START, DATA, PAR, STOP, WAIT_HI.
REQ-017 SHALL move from IDLE to START on an RXS 1->0 transition.
REQ-018 SHALL take one sample per bit as the majority of RXS at cycle offsets H-1, H and H+1 into the bit, where H = CLKS_PER_BIT/2 (integer division).
REQ-019 SHALL return to IDLE from START if the start-bit majority is 1 (glitch rejection); no VALID, no flags.
REQ-020 SHALL shift DATA_BITS samples LSB-first in DATA, then go to PAR if PARITY is not 0, else to STOP.
REQ-021 SHALL set the parity error in PAR when the XOR of data and parity samples is 0 for odd parity, or 1 for even parity.
REQ-022 SHALL sample STOP_BITS stop bits in STOP; any stop sample of 0 sets the frame error.
REQ-023 SHALL deliver the frame in the cycle after the last stop-bit majority decision, and SHALL NOT wait for the end of the stop bit.
REQ-024 SHALL, after delivery, go to IDLE if the last stop sample was 1, else to WAIT_HI; WAIT_HI exits to IDLE only once RXS is 1 (break handling).
REQ-025 SHALL, on delivery when VALID is 0 or READY is 1 in the same cycle, load DATA, PARITY_ERR and FRAME_ERR and set VALID.
REQ-026 SHALL, on delivery when VALID is 1 and READY is 0, keep the held frame unchanged, drop the new frame, and pulse OVERRUN for one cycle.
REQ-027 SHALL clear VALID the cycle after a VALID and READY handshake with no delivery in that cycle.
REQ-028 SHALL keep DATA and the error flags stable while VALID is 1.
REQ-029 SHALL count bit timing with a counter of width clog2(CLKS_PER_BIT); the counter resets at every bit boundary with no cumulative drift.
REQ-030 SHALL continue reception in parallel with a pending VALID; the output register is single-entry.

Reset
REQ-031 SHALL, when RESET is 1 at a clock edge, set the state to IDLE, the synchronizer flops to 1, the counters to 0, and DATA, VALID, PARITY_ERR, FRAME_ERR, OVERRUN and BUSY to 0.
REQ-032 SHALL, on RESET mid-frame, discard the partial frame; the next start edge after RESET releases begins a clean frame.
REQ-033 SHALL ignore READY and RX while RESET is 1.

Verification
REQ-034 SHALL pass this scenario: CLKS_PER_BIT=16, 8N1, byte 0xA5 sent with READY=1 -> one VALID pulse, DATA=0xA5, PARITY_ERR=0, FRAME_ERR=0.
REQ-035 SHALL pass this scenario: DATA_BITS=7, PARITY=2 (even), 0x35 sent with a wrong parity bit -> VALID, DATA=0x35, PARITY_ERR=1.
REQ-036 SHALL pass this scenario: 4-cycle low glitch on RX in IDLE -> BUSY returns to 0 within 10 cycles, no VALID.
REQ-037 SHALL pass this scenario: READY=0, two frames 0x11 then 0x22 -> OVERRUN pulses once, DATA stays 0x11; READY=1 then accepts 0x11 and VALID drops.
REQ-038 SHALL pass this scenario: STOP_BITS=2, second stop bit low, then RX held low for 40 cycles -> FRAME_ERR=1, BUSY stays 1 until RX returns high, and no spurious frame follows.
REQ-039 SHALL pass this scenario: RESET asserted at data bit 3 of a frame -> all outputs 0 next cycle; the next full frame 0x3C is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver with majority-vote bit sampling,
// optional parity, one or two checked stop bits, break handling and a
// single-entry VALID/READY output register with overrun indication.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 RX,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 VALID,
  input  logic                 READY,
  output logic                 PARITY_ERR,
  output logic                 FRAME_ERR,
  output logic                 OVERRUN,
  output logic                 BUSY
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] SMP_PRE  = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] SMP_MID  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] SMP_POST = CNT_W'(HALF + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_PAR     = 3'd3;
  localparam logic [2:0] S_STOP    = 3'd4;
  localparam logic [2:0] S_WAIT_HI = 3'd5;

  // Synchronizer and edge history
  logic rx_meta_q, rxs_q, rxs_prev_q;

  // Receive datapath state
  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  // Output register
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 overrun_q, overrun_d;

  logic maj;
  logic in_bit;
  logic decide;
  logic boundary;
  logic deliver;
  logic par_xor;

  // Two-flop synchronizer plus one history flop for start-edge detection
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= RX;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Receive FSM: bit timing, majority sampling, shifting and error capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    samp_d  = samp_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    deliver = 1'b0;

    // The third vote is the live synchronized sample at offset HALF+1.
    maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    in_bit   = (state_q == S_START) || (state_q == S_DATA) ||
               (state_q == S_PAR)   || (state_q == S_STOP);
    decide   = in_bit && (cnt_q == SMP_POST);
    boundary = in_bit && (cnt_q == CNT_LAST);
    par_xor  = (^shift_q) ^ maj;

    if (in_bit) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_ONE;
      if (cnt_q == SMP_PRE) samp_d[0] = rxs_q;
      if (cnt_q == SMP_MID) samp_d[1] = rxs_q;
    end

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (rxs_prev_q && !rxs_q) begin
          // The edge-detect cycle is offset 0 of the start bit.
          state_d = S_START;
          cnt_d   = CNT_ONE;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      S_START: begin
        if (decide && maj) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (boundary) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {maj, shift_q[DATA_BITS-1:1]};
        if (boundary) begin
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PAR: begin
        if (decide) perr_d = (PARITY == 1) ? ~par_xor : par_xor;
        if (boundary) state_d = S_STOP;
      end
      S_STOP: begin
        if (decide) begin
          if (!maj) ferr_d = 1'b1;
          if (bit_q == LAST_STOP) begin
            // Deliver on the last stop-bit decision instead of waiting
            // out the stop bit, so a back-to-back start edge is not missed.
            deliver = 1'b1;
            state_d = maj ? S_IDLE : S_WAIT_HI;
            cnt_d   = '0;
            bit_d   = '0;
          end
        end else if (boundary) begin
          bit_d = bit_q + 4'd1;
        end
      end
      S_WAIT_HI: begin
        cnt_d = '0;
        if (rxs_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Single-entry output register with overrun detection
  always_comb begin
    data_d     = data_q;
    valid_d    = valid_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    overrun_d  = 1'b0;
    if (deliver) begin
      if (!valid_q || READY) begin
        data_d     = shift_q;
        perr_out_d = perr_q;
        ferr_out_d = ferr_q | ~maj;
        valid_d    = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && READY) begin
      valid_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      samp_q     <= '0;
      shift_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      overrun_q  <= overrun_d;
    end
  end

  assign DATA       = data_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_out_q;
  assign FRAME_ERR  = ferr_out_q;
  assign OVERRUN    = overrun_q;
  assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg using three instances:
// u0 8N1, u1 7E1, u2 8O2, all at 16 clocks per bit.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic ready0 = 1'b1, ready1 = 1'b1, ready2 = 1'b1;

  logic [7:0] data0, data2;
  logic [6:0] data1;
  logic valid0, perr0, ferr0, ov0, busy0;
  logic valid1, perr1, ferr1, ov1, busy1;
  logic valid2, perr2, ferr2, ov2, busy2;

  int nvec = 0;
  int nmis = 0;
  int ov_cnt0 = 0;

  frame_t q0[$], q1[$], q2[$];
  frame_t e0, e1, e2;

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK(clk), .RESET(rst), .RX(rx0), .DATA(data0), .VALID(valid0), .READY(ready0),
    .PARITY_ERR(perr0), .FRAME_ERR(ferr0), .OVERRUN(ov0), .BUSY(busy0));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .CLK(clk), .RESET(rst), .RX(rx1), .DATA(data1), .VALID(valid1), .READY(ready1),
    .PARITY_ERR(perr1), .FRAME_ERR(ferr1), .OVERRUN(ov1), .BUSY(busy1));

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) u2 (
    .CLK(clk), .RESET(rst), .RX(rx2), .DATA(data2), .VALID(valid2), .READY(ready2),
    .PARITY_ERR(perr2), .FRAME_ERR(ferr2), .OVERRUN(ov2), .BUSY(busy2));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic void spurious(input string nm, input logic [31:0] act);
    nvec++;
    nmis++;
    $display("FAIL %s: got VALID with DATA 0x%0h, expected no frame", nm, act);
  endfunction

  // Monitors: compare on every handshake against the scoreboard queues
  always @(negedge clk) begin
    if (!rst && valid0 && ready0) begin
      if (q0.size() == 0) spurious("u0_frame", {24'h0, data0});
      else begin
        e0 = q0.pop_front();
        chk("u0_frame", {21'h0, 1'b0, data0, perr0, ferr0}, {21'h0, e0.data, e0.perr, e0.ferr});
      end
    end
    if (ov0) ov_cnt0++;
  end

  always @(negedge clk) begin
    if (!rst && valid1 && ready1) begin
      if (q1.size() == 0) spurious("u1_frame", {25'h0, data1});
      else begin
        e1 = q1.pop_front();
        chk("u1_frame", {21'h0, 2'b0, data1, perr1, ferr1}, {21'h0, e1.data, e1.perr, e1.ferr});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid2 && ready2) begin
      if (q2.size() == 0) spurious("u2_frame", {24'h0, data2});
      else begin
        e2 = q2.pop_front();
        chk("u2_frame", {21'h0, 1'b0, data2, perr2, ferr2}, {21'h0, e2.data, e2.perr, e2.ferr});
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int idx, input logic v);
    case (idx)
      0: rx0 = v;
      1: rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Sends n line bits, bit 0 first, each one bit period long
  task automatic send(input int idx, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(idx, bits[i]);
      wait_cyc(CPB);
    end
  endtask

  task automatic push0(input logic [7:0] d, input logic p, input logic f);
    frame_t t;
    t.data = {1'b0, d}; t.perr = p; t.ferr = f;
    q0.push_back(t);
  endtask

  task automatic push1(input logic [6:0] d, input logic p, input logic f);
    frame_t t;
    t.data = {2'b0, d}; t.perr = p; t.ferr = f;
    q1.push_back(t);
  endtask

  task automatic push2(input logic [7:0] d, input logic p, input logic f);
    frame_t t;
    t.data = {1'b0, d}; t.perr = p; t.ferr = f;
    q2.push_back(t);
  endtask

  initial begin
    int k;
    wait_cyc(3);
    chk("u0_reset_outs", {20'h0, valid0, busy0, ov0, perr0, ferr0, data0}, 32'h0);
    chk("u1_reset_outs", {21'h0, valid1, busy1, ov1, perr1, ferr1, data1}, 32'h0);
    chk("u2_reset_outs", {20'h0, valid2, busy2, ov2, perr2, ferr2, data2}, 32'h0);
    rst = 1'b0;
    wait_cyc(5);

    // 8N1 frames, READY held high
    push0(8'hA5, 1'b0, 1'b0);
    send(0, {6'h0, 1'b1, 8'hA5, 1'b0}, 10);
    wait_cyc(10);
    push0(8'h5A, 1'b0, 1'b0);
    send(0, {6'h0, 1'b1, 8'h5A, 1'b0}, 10);
    push0(8'hFF, 1'b0, 1'b0);
    send(0, {6'h0, 1'b1, 8'hFF, 1'b0}, 10);
    // Stop bit low: frame error, then line returns high
    push0(8'h00, 1'b0, 1'b1);
    send(0, {6'h0, 1'b0, 8'h00, 1'b0}, 10);
    wait_cyc(10);
    rx0 = 1'b1;
    wait_cyc(20);

    // 7E1 parity checks: 0x35 has four ones, 0x01 one, 0x7F seven
    push1(7'h35, 1'b1, 1'b0);
    send(1, {6'h0, 1'b1, 1'b1, 7'h35, 1'b0}, 10);
    push1(7'h35, 1'b0, 1'b0);
    send(1, {6'h0, 1'b1, 1'b0, 7'h35, 1'b0}, 10);
    push1(7'h01, 1'b0, 1'b0);
    send(1, {6'h0, 1'b1, 1'b1, 7'h01, 1'b0}, 10);
    push1(7'h7F, 1'b1, 1'b0);
    send(1, {6'h0, 1'b1, 1'b0, 7'h7F, 1'b0}, 10);
    wait_cyc(10);

    // Start-bit glitch of 4 cycles is rejected
    rx0 = 1'b0;
    wait_cyc(4);
    chk("u0_glitch_busy_set", {31'h0, busy0}, 32'h1);
    rx0 = 1'b1;
    k = 0;
    while (busy0 && k < 10) begin
      wait_cyc(1);
      k++;
    end
    chk("u0_glitch_busy_clear", {31'h0, busy0}, 32'h0);
    wait_cyc(30);

    // Overrun: two frames with READY low, second is dropped
    ready0 = 1'b0;
    push0(8'h11, 1'b0, 1'b0);
    send(0, {6'h0, 1'b1, 8'h11, 1'b0}, 10);
    send(0, {6'h0, 1'b1, 8'h22, 1'b0}, 10);
    wait_cyc(10);
    chk("u0_overrun_pulses", ov_cnt0, 32'd1);
    chk("u0_held_data", {24'h0, data0}, 32'h11);
    chk("u0_held_valid", {31'h0, valid0}, 32'h1);
    ready0 = 1'b1;
    wait_cyc(2);
    chk("u0_valid_after_accept", {31'h0, valid0}, 32'h0);

    // 8O2: good frame, break in second stop bit, recovery, parity error
    push2(8'h81, 1'b0, 1'b0);
    send(2, {4'h0, 2'b11, 1'b1, 8'h81, 1'b0}, 12);
    wait_cyc(10);
    push2(8'h3A, 1'b0, 1'b1);
    send(2, {4'h0, 1'b0, 1'b1, 1'b1, 8'h3A, 1'b0}, 12);
    wait_cyc(40);
    chk("u2_break_busy", {31'h0, busy2}, 32'h1);
    rx2 = 1'b1;
    k = 0;
    while (busy2 && k < 10) begin
      wait_cyc(1);
      k++;
    end
    chk("u2_break_busy_clear", {31'h0, busy2}, 32'h0);
    wait_cyc(60);
    push2(8'h81, 1'b1, 1'b0);
    send(2, {4'h0, 2'b11, 1'b0, 8'h81, 1'b0}, 12);
    wait_cyc(10);

    // Reset during data bit 3, then a clean frame
    send(0, {6'h0, 1'b1, 8'h3C, 1'b0}, 4);
    rx0 = 1'b1;
    wait_cyc(8);
    chk("u0_busy_mid_frame", {31'h0, busy0}, 32'h1);
    rst = 1'b1;
    wait_cyc(1);
    chk("u0_midframe_reset_outs", {20'h0, valid0, busy0, ov0, perr0, ferr0, data0}, 32'h0);
    rst = 1'b0;
    wait_cyc(20);
    push0(8'h3C, 1'b0, 1'b0);
    send(0, {6'h0, 1'b1, 8'h3C, 1'b0}, 10);
    wait_cyc(30);

    chk("u0_queue_drained", q0.size(), 32'd0);
    chk("u1_queue_drained", q1.size(), 32'd0);
    chk("u2_queue_drained", q2.size(), 32'd0);
    chk("u0_overrun_total", ov_cnt0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
